life_next_state: RTL and testbench

Computes the next Game-of-Life generation for one full frame. It streams the current frame store in raster order, one pixel per `step` strobe, and slides a 3x3 neighbourhood window over the frame using two line buffers. It writes each next-state pixel into the next-frame store through that store's `addr_write`/`ram_enable`/`data_write` port. It sits directly upstream of the next-frame RAM.

---
 rtl/life_pkg.sv | 16 +
 rtl/life_next_state_if.sv | 26 ++
 rtl/life_line_buffer.sv | 24 ++
 rtl/life_next_state.sv | 150 +++++++++++++++
 tb/tb_life_next_state.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/life_pkg.sv
// Shared constants and FSM state type for the Game-of-Life next-generation engine.
package life_pkg;
    localparam int unsigned WIDTH_DEFAULT  = 800;
    localparam int unsigned HEIGHT_DEFAULT = 525;
    localparam int unsigned ADDR_W         = 19;
    localparam int unsigned PIX_W          = 3;

    localparam logic [PIX_W-1:0] DEAD        = 3'b000;
    localparam logic [PIX_W-1:0] ALIVE_COLOR = 3'b111;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } state_e;
endpackage

// File: rtl/life_next_state_if.sv
// Frame-store bus: read port of the current frame, write port of the next frame.
interface life_next_state_if;
    import life_pkg::*;

    logic [ADDR_W-1:0] cur_addr;
    logic [PIX_W-1:0]  cur_data;
    logic [ADDR_W-1:0] addr_write;
    logic [PIX_W-1:0]  data_write;
    logic              ram_enable;

    modport master (
        output cur_addr,
        input  cur_data,
        output addr_write,
        output data_write,
        output ram_enable
    );

    modport slave (
        input  cur_addr,
        output cur_data,
        input  addr_write,
        input  data_write,
        input  ram_enable
    );
endinterface

// File: rtl/life_line_buffer.sv
// One-bit shift-register line delay; dout is the bit shifted in DEPTH enables ago.
module life_line_buffer
    import life_pkg::*;
#(
    parameter int unsigned DEPTH = WIDTH_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic din,
    output logic dout
);
    logic [DEPTH-1:0] sr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else if (en) begin
            sr_q <= {sr_q[DEPTH-2:0], din};
        end
    end

    assign dout = sr_q[DEPTH-1];
endmodule

// File: rtl/life_next_state.sv
// Streams one frame in raster order and writes the next Game-of-Life generation,
// using two line buffers and a 3x3 window whose newest column is the incoming pixel.
module life_next_state #(
    parameter int unsigned                 WIDTH       = life_pkg::WIDTH_DEFAULT,
    parameter int unsigned                 HEIGHT      = life_pkg::HEIGHT_DEFAULT,
    parameter logic [life_pkg::PIX_W-1:0]  ALIVE_COLOR = life_pkg::ALIVE_COLOR
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      step,
    input  logic                      start,
    life_next_state_if.master         mem,
    output logic                      busy,
    output logic                      done
);
    import life_pkg::*;

    localparam int unsigned TOTAL = WIDTH * HEIGHT;
    localparam int unsigned CNT_W = $clog2(TOTAL + WIDTH + 2);
    localparam int unsigned XW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned YW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic [CNT_W-1:0] TOTAL_C  = CNT_W'(TOTAL);
    localparam logic [CNT_W-1:0] WIDTH_C  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] WR_FIRST = CNT_W'(WIDTH + 1);
    localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(TOTAL + WIDTH);
    localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(TOTAL + WIDTH + 1);
    localparam logic [XW-1:0]    X_MAX    = XW'(WIDTH - 1);
    localparam logic [YW-1:0]    Y_MAX    = YW'(HEIGHT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] n_q;
    logic [XW-1:0]    x_q;
    logic [YW-1:0]    y_q;
    // Registered window columns per row: bit 0 = centre column, bit 1 = left column.
    logic [1:0]       r0_q, r1_q, r2_q;
    logic             alive_in, lb0_out, lb1_out, adv, wr_phase, next_alive;
    logic             m_l, m_r, m_t, m_b;
    logic [7:0]       nb;
    logic [3:0]       nb_cnt;

    // Pixel n_q is on cur_data now; addresses past the frame read as dead.
    assign alive_in = (n_q < TOTAL_C) && (mem.cur_data != DEAD);
    assign adv      = step && (state_q == StScan);
    assign wr_phase = (n_q >= WR_FIRST) && (n_q <= WR_LAST);

    life_line_buffer #(.DEPTH(WIDTH)) u_lb0 (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (adv),
        .din  (alive_in),
        .dout (lb0_out)
    );

    life_line_buffer #(.DEPTH(WIDTH)) u_lb1 (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (adv),
        .din  (lb0_out),
        .dout (lb1_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (step && start) state_d = StScan;
            StScan:  if (step && (n_q == LAST_C)) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q == StScan);
        done = (state_q == StDone);
    end

    // Edge masks for the centre pixel; rows: r2 = line above, r0 = line below.
    always_comb begin
        m_l    = (x_q != '0);
        m_r    = (x_q != X_MAX);
        m_t    = (y_q != '0);
        m_b    = (y_q != Y_MAX);
        nb[0]  = r2_q[1] & m_t & m_l;
        nb[1]  = r2_q[0] & m_t;
        nb[2]  = lb1_out & m_t & m_r;
        nb[3]  = r1_q[1] & m_l;
        nb[4]  = lb0_out & m_r;
        nb[5]  = r0_q[1] & m_b & m_l;
        nb[6]  = r0_q[0] & m_b;
        nb[7]  = alive_in & m_b & m_r;
        nb_cnt = '0;
        for (int i = 0; i < 8; i++) begin
            nb_cnt = nb_cnt + {3'b000, nb[i]};
        end
        next_alive = (nb_cnt == 4'd3) || (r1_q[0] && (nb_cnt == 4'd2));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q            <= '0;
            x_q            <= '0;
            y_q            <= '0;
            r0_q           <= '0;
            r1_q           <= '0;
            r2_q           <= '0;
            mem.cur_addr   <= '0;
            mem.addr_write <= '0;
            mem.data_write <= DEAD;
            mem.ram_enable <= 1'b0;
        end else if (step) begin
            if ((state_q == StIdle) && start) begin
                n_q            <= '0;
                x_q            <= '0;
                y_q            <= '0;
                r0_q           <= '0;
                r1_q           <= '0;
                r2_q           <= '0;
                mem.cur_addr   <= '0;
                mem.ram_enable <= 1'b0;
            end else if (state_q == StScan) begin
                n_q            <= n_q + CNT_W'(1);
                mem.cur_addr   <= (n_q < TOTAL_C - CNT_W'(1)) ? ADDR_W'(n_q + CNT_W'(1))
                                                              : ADDR_W'(TOTAL_C - CNT_W'(1));
                r0_q           <= {r0_q[0], alive_in};
                r1_q           <= {r1_q[0], lb0_out};
                r2_q           <= {r2_q[0], lb1_out};
                mem.ram_enable <= wr_phase;
                if (wr_phase) begin
                    mem.addr_write <= ADDR_W'(n_q - WIDTH_C);
                    mem.data_write <= next_alive ? ALIVE_COLOR : DEAD;
                    if (x_q == X_MAX) begin
                        x_q <= '0;
                        y_q <= y_q + YW'(1);
                    end else begin
                        x_q <= x_q + XW'(1);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_life_next_state.sv
// Directed bench for life_next_state on an 8x6 frame with a golden-model scoreboard.
module tb_life_next_state;
    import life_pkg::*;

    localparam int W   = 8;
    localparam int H   = 6;
    localparam int TOT = W * H;
    localparam int LAT = W + 2;

    typedef struct packed {
        logic [18:0] addr;
        logic [2:0]  data;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       step;
    logic       busy, done;
    logic [1:0] ph    = 2'd0;
    logic [2:0] frame [TOT];

    exp_t sb [$];
    int   checks   = 0;
    int   errors   = 0;
    int   wr_cnt   = 0;
    int   done_cnt = 0;
    int   per_cnt  = 0;

    life_next_state_if bus ();

    life_next_state #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .step (step),
        .start(start),
        .mem  (bus),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ph <= ph + 2'd1;
    assign step = (ph == 2'd3);

    // Current-frame store: one-clk read latency, well inside a pixel period.
    always @(posedge clk) bus.cur_data <= frame[bus.cur_addr[5:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_next(int x, int y);
        int cnt = 0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                if ((dx != 0 || dy != 0) && (x + dx >= 0) && (x + dx < W) &&
                    (y + dy >= 0) && (y + dy < H)) begin
                    if (frame[(y + dy) * W + x + dx] != 3'b000) cnt++;
                end
            end
        end
        return (cnt == 3) || ((frame[y * W + x] != 3'b000) && (cnt == 2));
    endfunction

    // Commit-side monitor: a write is taken on the step edge that follows this negedge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            per_cnt = 0;
        end else begin
            if (step) begin
                if (bus.ram_enable) begin
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("addr_write", 32'(bus.addr_write), 32'(e.addr));
                        chk("data_write", 32'(bus.data_write), 32'(e.data));
                        chk("write_latency", per_cnt, 32'(e.addr) - 1 + LAT);
                    end
                    wr_cnt++;
                end
                if (busy) per_cnt++;
                else per_cnt = 0;
            end
            if (done) done_cnt++;
        end
    end

    task automatic clear_frame();
        for (int i = 0; i < TOT; i++) frame[i] = 3'b000;
    endtask

    task automatic launch();
        exp_t e;
        sb.delete();
        wr_cnt   = 0;
        done_cnt = 0;
        for (int p = 0; p < TOT; p++) begin
            e.addr = 19'(p + 1);
            e.data = model_next(p % W, p / W) ? 3'b111 : 3'b000;
            sb.push_back(e);
        end
        @(negedge clk);
        while (!step) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic finish_gen(input bit poke);
        int t = 0;
        if (poke) begin
            repeat (60) @(negedge clk);
            start = 1'b1;
            repeat (12) @(negedge clk);
            start = 1'b0;
            chk("busy_during_poke", 32'(busy), 32'd1);
        end
        while (done_cnt == 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", done_cnt, 32'd1);
        repeat (40) @(negedge clk);
        chk("done_pulses", done_cnt, 32'd1);
        chk("write_count", wr_cnt, TOT);
        chk("sb_empty", sb.size(), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_ram_enable", 32'(bus.ram_enable), 32'd0);
    endtask

    initial begin
        int t;
        clear_frame();
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cur_addr", 32'(bus.cur_addr), 32'd0);
        chk("rst_addr_write", 32'(bus.addr_write), 32'd0);
        chk("rst_data_write", 32'(bus.data_write), 32'd0);
        chk("rst_ram_enable", 32'(bus.ram_enable), 32'd0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        // Empty frame.
        launch();
        finish_gen(1'b0);

        // Vertical blinker at (3,1),(3,2),(3,3); nonzero colours count as alive.
        frame[11] = 3'b101;
        frame[19] = 3'b111;
        frame[27] = 3'b010;
        launch();
        finish_gen(1'b0);

        // End-of-line and start-of-next-line cells must not see each other.
        clear_frame();
        frame[23] = 3'b001;
        frame[24] = 3'b111;
        launch();
        finish_gen(1'b0);

        // Still-life block in the top-left corner.
        clear_frame();
        frame[0] = 3'b111;
        frame[1] = 3'b111;
        frame[8] = 3'b111;
        frame[9] = 3'b111;
        launch();
        finish_gen(1'b0);

        // Abort a blinker generation at step 20, then rerun it.
        clear_frame();
        frame[11] = 3'b111;
        frame[19] = 3'b111;
        frame[27] = 3'b111;
        launch();
        t = 0;
        while (per_cnt < 20 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("abort_reached", per_cnt, 32'd20);
        rst_n = 1'b0;
        #1;
        chk("abort_writes", wr_cnt, 32'd10);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_cur_addr", 32'(bus.cur_addr), 32'd0);
        chk("abort_addr_write", 32'(bus.addr_write), 32'd0);
        chk("abort_data_write", 32'(bus.data_write), 32'd0);
        chk("abort_ram_enable", 32'(bus.ram_enable), 32'd0);
        sb.delete();
        repeat (8) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            chk("post_abort_quiet", 32'({busy, bus.ram_enable}), 32'd0);
        end
        launch();
        finish_gen(1'b0);

        // start pulsed mid-scan must not restart or extend the generation.
        launch();
        finish_gen(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
